// File: rtl/vol_pkg.sv
// Shared widths and default constants for the mic capture,
// volume-level and volume-bar renderer blocks.
package vol_pkg;
  localparam int LEVEL_W = 4;
  localparam int MIC_W = 12;
  localparam int DEF_WINDOW = 4000;
  localparam int DEF_BASELINE = 2048;
  localparam int DEF_SHIFT = 7;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
endpackage

// File: rtl/level_quantiser.sv
// Maps a window peak to a raw 0..15 level: baseline subtract,
// shift, saturate.
module level_quantiser
  import vol_pkg::*;
#(
  parameter int BASELINE = DEF_BASELINE,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [MIC_W-1:0]   pk,
  output logic [LEVEL_W-1:0] raw
);

  localparam logic [MIC_W:0] BASE = BASELINE[MIC_W:0];
  localparam logic [MIC_W:0] LMAX =
    {{(MIC_W+1-LEVEL_W){1'b0}}, LEVEL_MAX};

  logic [MIC_W:0] diff;
  logic [MIC_W:0] shd;

  always_comb begin
    diff = {1'b0, pk} - BASE;
    shd = diff >> SHIFT;
    raw = '0;
    if ({1'b0, pk} <= BASE) begin
      raw = '0;
    end else if (shd > LMAX) begin
      raw = LEVEL_MAX;
    end else begin
      raw = shd[LEVEL_W-1:0];
    end
  end

endmodule

// File: rtl/mic_volume_level.sv
// Windowed peak detector with fast-attack / slow-decay level
// output for the OLED volume bar.
module mic_volume_level
  import vol_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int BASELINE = DEF_BASELINE,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DECAY_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [11:0]  mic_in,
  output logic [3:0]   level,
  output logic         level_update,
  output logic [11:0]  peak
);

  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  logic [15:0]        cnt_q, cnt_d;
  logic [MIC_W-1:0]   cur_max_q, cur_max_d;
  logic [MIC_W-1:0]   peak_q, peak_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               upd_q, upd_d;

  logic [MIC_W-1:0]   pk;
  logic [LEVEL_W-1:0] raw;
  logic [LEVEL_W-1:0] next_level;

  level_quantiser #(
    .BASELINE (BASELINE),
    .SHIFT    (SHIFT)
  ) u_quant (
    .pk  (pk),
    .raw (raw)
  );

  // Running max including the current sample, so the
  // window-end sample is folded into the peak.
  always_comb begin
    pk = (mic_in > cur_max_q) ? mic_in : cur_max_q;
  end

  // raw < level implies level >= 1, so decay cannot underflow.
  always_comb begin
    next_level = raw;
    if (raw < level_q && DECAY_EN != 0) begin
      next_level = level_q - 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    cur_max_d = cur_max_q;
    peak_d = peak_q;
    level_d = level_q;
    upd_d = 1'b0;
    if (sample_valid) begin
      if (cnt_q == LAST) begin
        peak_d = pk;
        cur_max_d = '0;
        cnt_d = '0;
        upd_d = 1'b1;
        level_d = next_level;
      end else begin
        cur_max_d = pk;
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cur_max_q <= '0;
      peak_q <= '0;
      level_q <= '0;
      upd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cur_max_q <= cur_max_d;
      peak_q <= peak_d;
      level_q <= level_d;
      upd_q <= upd_d;
    end
  end

  assign level = level_q;
  assign level_update = upd_q;
  assign peak = peak_q;

endmodule
